complex_result_serializer: RTL



---
 rtl/complex_pkg.sv | 19 +
 rtl/complex_result_serializer.sv | 92 +++++++++
 2 files changed

// File: rtl/complex_pkg.sv
// Shared definitions for the complex-number datapath: operand widths, the
// {imag, real} word type and the result serializer state encoding.
package complex_pkg;

  localparam int unsigned DATA_W  = 10;
  localparam int unsigned CHUNK_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // The field is named "re" because "real" is a reserved word.
  typedef struct packed {
    logic [DATA_W-1:0] imag;
    logic [DATA_W-1:0] re;
  } complex_t;

endpackage

// File: rtl/complex_result_serializer.sv
// Unloads one parallel complex word {imag, real} as BEATS narrow chunks,
// real LSB chunk first, with out_last on the final chunk.
module complex_result_serializer #(
  parameter int unsigned DATA_W  = complex_pkg::DATA_W,
  parameter int unsigned CHUNK_W = complex_pkg::CHUNK_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  in_real,
  input  logic [DATA_W-1:0]  in_imag,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [CHUNK_W-1:0] out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready
);
  import complex_pkg::*;

  localparam int unsigned WORD_W = 2 * DATA_W;
  localparam int unsigned BEATS  = WORD_W / CHUNK_W;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                ready_en_q, ready_en_d;

  logic                out_fire;
  logic                last_fire;
  logic                in_fire;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ready_en_q  <= ready_en_d;
    end
  end

  // Next-state, handshakes and shift control
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    ready_en_d  = 1'b1;

    out_fire  = out_valid_q && out_ready;
    last_fire = out_fire && out_last_q;
    // A new word may be taken on the same edge the last beat leaves.
    in_ready  = ready_en_q && ((state_q == IDLE) || last_fire);
    in_fire   = in_valid && in_ready;

    if (in_fire) begin
      shreg_d     = {in_imag, in_real};
      cnt_d       = '0;
      state_d     = SEND;
      out_valid_d = 1'b1;
      out_last_d  = (BEATS == 1);
    end else if (last_fire) begin
      shreg_d     = shreg_q >> CHUNK_W;
      cnt_d       = '0;
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (out_fire) begin
      shreg_d     = shreg_q >> CHUNK_W;
      cnt_d       = cnt_q + CNT_W'(1);
      out_last_d  = (cnt_d == CNT_W'(BEATS - 1));
    end
  end

  assign out_data  = shreg_q[CHUNK_W-1:0];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
